// File: rtl/timing_gen_if.sv
// timing_gen_if: runtime timing load channel (valid/ready).
// cfg_h/cfg_v pack {sync,bp,active,fp}, sync in the top W bits.
interface timing_gen_if #(
  parameter int W = 16
);
  logic           cfg_valid;
  logic           cfg_ready;
  logic [4*W-1:0] cfg_h;
  logic [4*W-1:0] cfg_v;

  modport master (
    output cfg_valid,
    output cfg_h,
    output cfg_v,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_h,
    input  cfg_v,
    output cfg_ready
  );
endinterface

// File: rtl/timing_gen.sv
// timing_gen: raster timing generator, boot timing from parameters,
// runtime timing via cfg (timing_gen_if.slave) applied at frame boundaries.
// Ports: clk, reset_n (async, active low), cfg, x, y, hsync, vsync,
// visible, line_start, frame_start. With TIMING_PREFETCH_EN defined:
// fetch_valid/fetch_x/fetch_y lead the outputs by PREFETCH cycles.
module timing_gen #(
  parameter int W         = 16,
  parameter int H_SYNC    = 40,
  parameter int H_BP      = 220,
  parameter int H_ACTIVE  = 1280,
  parameter int H_FP      = 110,
  parameter int V_SYNC    = 5,
  parameter int V_BP      = 20,
  parameter int V_ACTIVE  = 720,
  parameter int V_FP      = 5,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1,
  parameter int PREFETCH  = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  timing_gen_if.slave  cfg,
  output logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic         hsync,
  output logic         vsync,
  output logic         visible,
  output logic         line_start,
  output logic         frame_start
`ifdef TIMING_PREFETCH_EN
  ,
  output logic         fetch_valid,
  output logic [W-1:0] fetch_x,
  output logic [W-1:0] fetch_y
`endif
);

  if (PREFETCH < 1 || PREFETCH > 15) begin : g_bad_prefetch
    $error("PREFETCH must be 1..15");
  end

  localparam logic [1:0] S_SYNC = 2'd0;
  localparam logic [1:0] S_BP   = 2'd1;
  localparam logic [1:0] S_ACT  = 2'd2;
  localparam logic [1:0] S_FP   = 2'd3;

  localparam int OW = 2*W + 5;

  // Timing fields indexed by FSM state: [0]=sync ... [3]=fp.
  typedef logic [3:0][W-1:0] tmg_t;

  localparam tmg_t H_BOOT = {
    W'(H_FP), W'(H_ACTIVE), W'(H_BP), W'(H_SYNC)
  };
  localparam tmg_t V_BOOT = {
    W'(V_FP), W'(V_ACTIVE), W'(V_BP), W'(V_SYNC)
  };
  localparam logic [OW-1:0] O_RST = {
    {(2*W){1'b0}}, ~HSYNC_POL, ~VSYNC_POL, 3'b000
  };

  function automatic tmg_t load(input logic [4*W-1:0] c);
    tmg_t t;
    for (int i = 0; i < 4; i++) begin
      t[i] = c[(3-i)*W +: W];
      if (t[i] == '0) t[i] = W'(1);
    end
    return t;
  endfunction

  logic [1:0]    hst_q, hst_d, vst_q, vst_d;
  logic [W-1:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  tmg_t          hlive_q, hlive_d, vlive_q, vlive_d;
  tmg_t          hshd_q, hshd_d, vshd_q, vshd_d;
  logic          pend_q, pend_d;
  logic [OW-1:0] core_q, core_d;
  logic [OW-1:0] out;
  logic          h_last, v_last;
  logic          line_end, frame_end;
  logic          take, vis;

  assign cfg.cfg_ready = ~pend_q;

  always_comb begin
    h_last    = hcnt_q == hlive_q[hst_q] - W'(1);
    v_last    = vcnt_q == vlive_q[vst_q] - W'(1);
    line_end  = h_last && (hst_q == S_FP);
    frame_end = line_end && v_last
              && (vst_q == S_FP);
    take      = cfg.cfg_valid && ~pend_q;

    hst_d  = hst_q;
    hcnt_d = hcnt_q + W'(1);
    if (h_last) begin
      hst_d  = hst_q + 2'd1;
      hcnt_d = '0;
    end

    vst_d  = vst_q;
    vcnt_d = vcnt_q;
    if (line_end) begin
      vcnt_d = vcnt_q + W'(1);
      if (v_last) begin
        vst_d  = vst_q + 2'd1;
        vcnt_d = '0;
      end
    end

    hlive_d = hlive_q;
    vlive_d = vlive_q;
    hshd_d  = hshd_q;
    vshd_d  = vshd_q;
    pend_d  = pend_q;
    if (take) begin
      hshd_d = load(cfg.cfg_h);
      vshd_d = load(cfg.cfg_v);
      pend_d = 1'b1;
    end
    // take needs ~pend_q, so it never collides with this copy.
    if (frame_end && pend_q) begin
      hlive_d = hshd_q;
      vlive_d = vshd_q;
      pend_d  = 1'b0;
    end

    vis = (hst_q == S_ACT) && (vst_q == S_ACT);
    core_d = {
      vis ? hcnt_q : '0,
      (vst_q == S_ACT) ? vcnt_q : '0,
      HSYNC_POL ^ (hst_q != S_SYNC),
      VSYNC_POL ^ (vst_q != S_SYNC),
      vis,
      (hst_q == S_SYNC) && (hcnt_q == '0),
      (hst_q == S_SYNC) && (hcnt_q == '0)
        && (vst_q == S_SYNC) && (vcnt_q == '0)
    };
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hst_q   <= S_SYNC;
      vst_q   <= S_SYNC;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      hlive_q <= H_BOOT;
      vlive_q <= V_BOOT;
      hshd_q  <= H_BOOT;
      vshd_q  <= V_BOOT;
      pend_q  <= 1'b0;
      core_q  <= O_RST;
    end else begin
      hst_q   <= hst_d;
      vst_q   <= vst_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      hlive_q <= hlive_d;
      vlive_q <= vlive_d;
      hshd_q  <= hshd_d;
      vshd_q  <= vshd_d;
      pend_q  <= pend_d;
      core_q  <= core_d;
    end
  end

`ifdef TIMING_PREFETCH_EN
  logic [PREFETCH-1:0][OW-1:0] pipe_q, pipe_d;

  always_comb begin
    pipe_d[0] = core_q;
    for (int i = 1; i < PREFETCH; i++)
      pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pipe_q <= {PREFETCH{O_RST}};
    else          pipe_q <= pipe_d;
  end

  assign out         = pipe_q[PREFETCH-1];
  assign fetch_valid = core_q[2];
  assign fetch_x     = core_q[2*W+4 -: W];
  assign fetch_y     = core_q[W+4 -: W];
`else
  assign out = core_q;
`endif

  assign {x, y, hsync, vsync,
          visible, line_start,
          frame_start} = out;

endmodule

// File: tb/tb_timing_gen.sv
// tb_timing_gen: directed bench for timing_gen with a small
// 14x7 raster (H=2/3/8/1, V=1/1/4/1) and runtime reloads.
module tb_timing_gen;
  localparam int W  = 16;
  localparam int OW = 2*W + 5;
`ifdef TIMING_PREFETCH_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 0;
`endif
  localparam logic [OW-1:0] RST = '0;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] x, y;
  logic         hsync, vsync, visible;
  logic         line_start, frame_start;
`ifdef TIMING_PREFETCH_EN
  logic         fetch_valid;
  logic [W-1:0] fetch_x, fetch_y;
`endif
  logic [OW-1:0] obs, exp_v;

  int n_chk = 0;
  int n_fail = 0;

  timing_gen_if #(.W(W)) cfg_if ();

  timing_gen #(
    .W(W),
    .H_SYNC(2), .H_BP(3), .H_ACTIVE(8), .H_FP(1),
    .V_SYNC(1), .V_BP(1), .V_ACTIVE(4), .V_FP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1),
    .PREFETCH(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .cfg(cfg_if),
    .x(x),
    .y(y),
    .hsync(hsync),
    .vsync(vsync),
    .visible(visible),
    .line_start(line_start),
    .frame_start(frame_start)
`ifdef TIMING_PREFETCH_EN
    ,
    .fetch_valid(fetch_valid),
    .fetch_x(fetch_x),
    .fetch_y(fetch_y)
`endif
  );

  always #5 clk = ~clk;

  assign obs = {x, y, hsync, vsync, visible,
                line_start, frame_start};

  // Expected {x,y,hs,vs,vis,ls,fs} at cycle c of a raster.
  function automatic logic [OW-1:0] model(
    int c, int hs, int hb, int ha, int hf,
    int vs, int vb, int va, int vf);
    int ht, vt, p, l;
    logic vh, vv;
    logic [W-1:0] ex, ey;
    ht = hs + hb + ha + hf;
    vt = vs + vb + va + vf;
    p  = c % ht;
    l  = (c / ht) % vt;
    vh = (p >= hs + hb) && (p < hs + hb + ha);
    vv = (l >= vs + vb) && (l < vs + vb + va);
    ex = (vh && vv) ? W'(p - hs - hb) : '0;
    ey = vv ? W'(l - vs - vb) : '0;
    return {ex, ey, p < hs, l < vs, vh && vv,
            p == 0, (p == 0) && (l == 0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release_rst();
    reset_n = 1'b1;
    repeat (LAT) tick();
  endtask

  task automatic offer(
    input logic [4*W-1:0] h,
    input logic [4*W-1:0] v);
    cfg_if.cfg_h     = h;
    cfg_if.cfg_v     = v;
    cfg_if.cfg_valid = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_h = '0;
    cfg_if.cfg_v = '0;
    repeat (3) tick();
    n_chk++;
    if (obs !== RST) begin
      n_fail++;
      $display("FAIL reset_out got %h want %h", obs, RST);
    end
    n_chk++;
    if (cfg_if.cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready got %b want 1",
               cfg_if.cfg_ready);
    end
  endtask

  task automatic test_first_frame();
    int nvis, nvs, nls;
    nvis = 0; nvs = 0; nls = 0;
    release_rst();
    for (int c = 0; c < 98; c++) begin
      tick();
      exp_v = model(c, 2, 3, 8, 1, 1, 1, 4, 1);
      n_chk++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL frame1 c=%0d got %h want %h",
                 c, obs, exp_v);
      end
      nvis += int'(visible);
      nvs  += int'(vsync);
      nls  += int'(line_start);
    end
    n_chk++;
    if (nvis !== 32) begin
      n_fail++;
      $display("FAIL vis_count got %0d want 32", nvis);
    end
    n_chk++;
    if (nvs !== 14) begin
      n_fail++;
      $display("FAIL vsync_count got %0d want 14", nvs);
    end
    n_chk++;
    if (nls !== 7) begin
      n_fail++;
      $display("FAIL ls_count got %0d want 7", nls);
    end
    tick();
    n_chk++;
    if ({frame_start, line_start, hsync} !== 3'b111) begin
      n_fail++;
      $display("FAIL period98 got %b want 111",
               {frame_start, line_start, hsync});
    end
  endtask

  task automatic test_async_reset();
    for (int c = 1; c <= 51; c++) begin
      tick();
      exp_v = model(c, 2, 3, 8, 1, 1, 1, 4, 1);
      n_chk++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL pre_rst c=%0d got %h want %h",
                 c, obs, exp_v);
      end
      if (c == 10)
        offer({16'd1, 16'd1, 16'd1, 16'd1},
              {16'd1, 16'd1, 16'd1, 16'd1});
      if (c == 11) cfg_if.cfg_valid = 1'b0;
      if (c == 20) begin
        n_chk++;
        if (cfg_if.cfg_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL pend_ready got %b want 0",
                   cfg_if.cfg_ready);
        end
      end
    end
    n_chk++;
    if ({x, y, visible} !== {16'd4, 16'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL l3x4 got x=%0d y=%0d v=%b want 4 1 1",
               x, y, visible);
    end
    #2 reset_n = 1'b0;
    #1;
    n_chk++;
    if (obs !== RST) begin
      n_fail++;
      $display("FAIL async_rst got %h want %h", obs, RST);
    end
    n_chk++;
    if (cfg_if.cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL async_ready got %b want 1",
               cfg_if.cfg_ready);
    end
    tick();
    tick();
    release_rst();
    for (int c = 0; c < 196; c++) begin
      tick();
      exp_v = model(c, 2, 3, 8, 1, 1, 1, 4, 1);
      n_chk++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL post_rst c=%0d got %h want %h",
                 c, obs, exp_v);
      end
    end
  endtask

  task automatic test_cfg_reload();
    int nvis, nls;
    nvis = 0; nls = 0;
    for (int c = 0; c < 98; c++) begin
      tick();
      exp_v = model(c, 2, 3, 8, 1, 1, 1, 4, 1);
      n_chk++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL old_tmg c=%0d got %h want %h",
                 c, obs, exp_v);
      end
      if (c == 20) begin
        n_chk++;
        if (cfg_if.cfg_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL ready_pre got %b want 1",
                   cfg_if.cfg_ready);
        end
        offer({16'd1, 16'd1, 16'd4, 16'd1},
              {16'd1, 16'd1, 16'd2, 16'd1});
      end
      if (c == 21) cfg_if.cfg_valid = 1'b0;
      if (c == 60) begin
        n_chk++;
        if (cfg_if.cfg_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL ready_held got %b want 0",
                   cfg_if.cfg_ready);
        end
      end
    end
    for (int c = 0; c < 35; c++) begin
      tick();
      exp_v = model(c, 1, 1, 4, 1, 1, 1, 2, 1);
      n_chk++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL new_tmg c=%0d got %h want %h",
                 c, obs, exp_v);
      end
      if (c == 0) begin
        n_chk++;
        if (cfg_if.cfg_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL ready_post got %b want 1",
                   cfg_if.cfg_ready);
        end
      end
      nvis += int'(visible);
      nls  += int'(line_start);
    end
    n_chk++;
    if (nvis !== 8 || nls !== 5) begin
      n_fail++;
      $display("FAIL new_counts got vis=%0d ls=%0d want 8 5",
               nvis, nls);
    end
  endtask

  task automatic test_cfg_zero();
    int nhs;
    nhs = 0;
    for (int c = 0; c < 35; c++) begin
      tick();
      exp_v = model(c, 1, 1, 4, 1, 1, 1, 2, 1);
      n_chk++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL z_frame c=%0d got %h want %h",
                 c, obs, exp_v);
      end
      if (c == 5)
        offer({16'd0, 16'd2, 16'd4, 16'd1},
              {16'd1, 16'd1, 16'd2, 16'd1});
      if (c == 6) begin
        cfg_if.cfg_valid = 1'b0;
        n_chk++;
        if (cfg_if.cfg_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL z_ready got %b want 0",
                   cfg_if.cfg_ready);
        end
      end
      if (c == 10)
        offer({16'd2, 16'd2, 16'd2, 16'd2},
              {16'd2, 16'd2, 16'd2, 16'd2});
      if (c == 15) begin
        n_chk++;
        if (cfg_if.cfg_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL busy_ready got %b want 0",
                   cfg_if.cfg_ready);
        end
        cfg_if.cfg_valid = 1'b0;
      end
    end
    for (int c = 0; c < 80; c++) begin
      tick();
      exp_v = model(c, 1, 2, 4, 1, 1, 1, 2, 1);
      n_chk++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL z_tmg c=%0d got %h want %h",
                 c, obs, exp_v);
      end
      nhs += int'(hsync);
    end
    n_chk++;
    if (nhs !== 10) begin
      n_fail++;
      $display("FAIL hs1_count got %0d want 10", nhs);
    end
  endtask

`ifdef TIMING_PREFETCH_EN
  task automatic test_prefetch();
    logic [2*W:0] fo, fe;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 102; k++) begin
      tick();
      exp_v = model(k, 2, 3, 8, 1, 1, 1, 4, 1);
      fe = {exp_v[2], exp_v[2*W+4 -: W], exp_v[W+4 -: W]};
      fo = {fetch_valid, fetch_x, fetch_y};
      n_chk++;
      if (fo !== fe) begin
        n_fail++;
        $display("FAIL fetch k=%0d got %h want %h",
                 k, fo, fe);
      end
      exp_v = (k < 4) ? RST
            : model(k - 4, 2, 3, 8, 1, 1, 1, 4, 1);
      n_chk++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL delayed k=%0d got %h want %h",
                 k, obs, exp_v);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_first_frame();
    test_async_reset();
    test_cfg_reload();
    test_cfg_zero();
`ifdef TIMING_PREFETCH_EN
    test_prefetch();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
